// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB with writeback completion, in-order commit and mispredict flush
module reorder_buffer #(
  parameter int ROB_ENTRY  = 16,
  parameter int PC_WIDTH   = 16,
  parameter int AREG_WIDTH = 3,
  parameter int PREG_WIDTH = 7,
  localparam int IW = $clog2(ROB_ENTRY)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  alloc_v_i,
  input  logic [PC_WIDTH-1:0]   alloc_pc_i,
  input  logic                  alloc_w_v_i,
  input  logic [AREG_WIDTH-1:0] alloc_reg_i,
  input  logic [PREG_WIDTH-1:0] alloc_freed_i,
  input  logic                  alloc_is_spec_i,
  output logic                  rob_ready_o,
  output logic [IW-1:0]         rob_num_o,
  input  logic                  wb_v_i,
  input  logic [IW-1:0]         wb_idx_i,
  input  logic                  wb_mispredict_i,
  input  logic [PC_WIDTH-1:0]   wb_target_pc_i,
  output logic                  commit_v_o,
  output logic                  commit_w_v_o,
  output logic [AREG_WIDTH-1:0] commit_alloc_reg_o,
  output logic [PREG_WIDTH-1:0] commit_freed_reg_o,
  output logic                  commit_mispredict_o,
  output logic [PC_WIDTH-1:0]   commit_pc_o,
  output logic [IW:0]           count_o
);
  // target holds the instruction PC until a speculated branch resolves, so commit_pc_o tracks program order
  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  w_v;
    logic [AREG_WIDTH-1:0] areg;
    logic [PREG_WIDTH-1:0] freed;
    logic                  is_spec;
    logic                  mispredict;
    logic [PC_WIDTH-1:0]   target;
  } entry_t;

  entry_t ent_q [ROB_ENTRY];
  entry_t ent_d [ROB_ENTRY];
  logic [IW:0] head_q, head_d, tail_q, tail_d;
  logic full, flush, alloc_fire, wb_fire;
  logic [IW-1:0] head_idx, tail_idx;
  entry_t hd;

  assign head_idx            = head_q[IW-1:0];
  assign tail_idx            = tail_q[IW-1:0];
  assign hd                  = ent_q[head_idx];
  assign full                = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
  assign commit_v_o          = hd.valid && hd.done;
  assign flush               = commit_v_o && hd.mispredict;
  assign commit_mispredict_o = flush;
  assign commit_w_v_o        = commit_v_o && hd.w_v;
  assign commit_alloc_reg_o  = commit_v_o ? hd.areg : '0;
  assign commit_freed_reg_o  = commit_v_o ? hd.freed : '0;
  assign commit_pc_o         = commit_v_o ? hd.target : '0;
  assign rob_ready_o         = !full && !flush;
  assign rob_num_o           = tail_idx;
  assign count_o             = tail_q - head_q;
  assign alloc_fire          = alloc_v_i && rob_ready_o;
  assign wb_fire             = wb_v_i && ent_q[wb_idx_i].valid && !flush;

  // next-state: writeback completion, head retirement, flush on mispredict, tail allocation
  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    if (wb_fire) begin
      ent_d[wb_idx_i].done = 1'b1;
      if (ent_q[wb_idx_i].is_spec) begin
        ent_d[wb_idx_i].mispredict = wb_mispredict_i;
        ent_d[wb_idx_i].target     = wb_target_pc_i;
      end
    end
    if (commit_v_o) begin
      ent_d[head_idx].valid = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (flush) begin
      for (int i = 0; i < ROB_ENTRY; i++) ent_d[i].valid = 1'b0;
      tail_d = head_q + 1'b1;
    end
    if (alloc_fire) begin
      ent_d[tail_idx] = '{valid: 1'b1, done: 1'b0, w_v: alloc_w_v_i, areg: alloc_reg_i,
                          freed: alloc_freed_i, is_spec: alloc_is_spec_i, mispredict: 1'b0,
                          target: alloc_pc_i};
      tail_d = tail_q + 1'b1;
    end
  end

  // state registers; reset discards every entry immediately
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ROB_ENTRY; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      ent_q  <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: table-driven and directed checks of the reorder buffer
module tb_reorder_buffer;
  logic        clk_i = 0, reset_i = 1;
  logic        alloc_v_i = 0, alloc_w_v_i = 0, alloc_is_spec_i = 0;
  logic [15:0] alloc_pc_i = 0, wb_target_pc_i = 0, commit_pc_o;
  logic [2:0]  alloc_reg_i = 0, commit_alloc_reg_o;
  logic [6:0]  alloc_freed_i = 0, commit_freed_reg_o;
  logic        rob_ready_o, wb_v_i = 0, wb_mispredict_i = 0;
  logic [3:0]  rob_num_o, wb_idx_i = 0;
  logic        commit_v_o, commit_w_v_o, commit_mispredict_o;
  logic [4:0]  count_o;
  int total = 0, fails = 0;

  reorder_buffer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_v_i(alloc_v_i), .alloc_pc_i(alloc_pc_i), .alloc_w_v_i(alloc_w_v_i),
    .alloc_reg_i(alloc_reg_i), .alloc_freed_i(alloc_freed_i), .alloc_is_spec_i(alloc_is_spec_i),
    .rob_ready_o(rob_ready_o), .rob_num_o(rob_num_o),
    .wb_v_i(wb_v_i), .wb_idx_i(wb_idx_i), .wb_mispredict_i(wb_mispredict_i),
    .wb_target_pc_i(wb_target_pc_i),
    .commit_v_o(commit_v_o), .commit_w_v_o(commit_w_v_o), .commit_alloc_reg_o(commit_alloc_reg_o),
    .commit_freed_reg_o(commit_freed_reg_o), .commit_mispredict_o(commit_mispredict_o),
    .commit_pc_o(commit_pc_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic av; logic [15:0] pc; logic [6:0] fr; logic sp;
    logic wv; logic [3:0] wi; logic wm; logic [15:0] wt;
    logic rdy; logic [3:0] num; logic cv; logic mp; logic [15:0] cpc; logic [4:0] cnt; logic [6:0] cfr;
  } vec_t;
  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle;
    alloc_v_i = 0; alloc_is_spec_i = 0; wb_v_i = 0; wb_mispredict_i = 0;
  endtask

  task automatic alloc(input logic [15:0] pc, input logic [6:0] fr, input logic sp);
    alloc_v_i = 1; alloc_pc_i = pc; alloc_freed_i = fr; alloc_reg_i = fr[2:0];
    alloc_w_v_i = 1; alloc_is_spec_i = sp;
  endtask

  task automatic wb(input logic [3:0] idx, input logic mp, input logic [15:0] tgt);
    wb_v_i = 1; wb_idx_i = idx; wb_mispredict_i = mp; wb_target_pc_i = tgt;
  endtask

  task automatic do_reset;
    idle();
    reset_i = 1;
    tick();
    reset_i = 0;
    #1;
  endtask

  initial begin
    vt[0]  = '{1, 16'h10, 7'h21, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0,     0, 0};
    vt[1]  = '{1, 16'h12, 7'h22, 0, 0, 0, 0, 0,     1, 1, 0, 0, 0,     1, 0};
    vt[2]  = '{1, 16'h14, 7'h23, 0, 0, 0, 0, 0,     1, 2, 0, 0, 0,     2, 0};
    vt[3]  = '{0, 0,      0,     0, 1, 2, 0, 0,     1, 3, 0, 0, 0,     3, 0};
    vt[4]  = '{0, 0,      0,     0, 1, 0, 0, 0,     1, 3, 0, 0, 0,     3, 0};
    vt[5]  = '{0, 0,      0,     0, 1, 1, 0, 0,     1, 3, 1, 0, 16'h10, 3, 7'h21};
    vt[6]  = '{0, 0,      0,     0, 0, 0, 0, 0,     1, 3, 1, 0, 16'h12, 2, 7'h22};
    vt[7]  = '{0, 0,      0,     0, 0, 0, 0, 0,     1, 3, 1, 0, 16'h14, 1, 7'h23};
    vt[8]  = '{0, 0,      0,     0, 0, 0, 0, 0,     1, 3, 0, 0, 0,     0, 0};
    vt[9]  = '{0, 0,      0,     0, 1, 5, 0, 0,     1, 3, 0, 0, 0,     0, 0};
    vt[10] = '{0, 0,      0,     0, 0, 0, 0, 0,     1, 3, 0, 0, 0,     0, 0};
    vt[11] = '{1, 16'h30, 7'h31, 0, 0, 0, 0, 0,     1, 3, 0, 0, 0,     0, 0};
    vt[12] = '{0, 0,      0,     0, 1, 3, 1, 16'h99, 1, 4, 0, 0, 0,    1, 0};
    vt[13] = '{0, 0,      0,     0, 0, 0, 0, 0,     1, 4, 1, 0, 16'h30, 1, 7'h31};
    vt[14] = '{0, 0,      0,     0, 0, 0, 0, 0,     1, 4, 0, 0, 0,     0, 0};

    #7;
    chk("reset_ready", rob_ready_o, 1);
    chk("reset_num", rob_num_o, 0);
    chk("reset_cv", commit_v_o, 0);
    chk("reset_mp", commit_mispredict_o, 0);
    chk("reset_count", count_o, 0);
    chk("reset_pc", commit_pc_o, 0);
    chk("reset_freed", commit_freed_reg_o, 0);
    do_reset();

    // in-order commit with out-of-order writeback, invalid writeback, non-spec mispredict
    for (int i = 0; i < 15; i++) begin
      idle();
      if (vt[i].av) alloc(vt[i].pc, vt[i].fr, vt[i].sp);
      if (vt[i].wv) wb(vt[i].wi, vt[i].wm, vt[i].wt);
      #1;
      chk($sformatf("v%0d_ready", i), rob_ready_o, vt[i].rdy);
      chk($sformatf("v%0d_num", i), rob_num_o, vt[i].num);
      chk($sformatf("v%0d_cv", i), commit_v_o, vt[i].cv);
      chk($sformatf("v%0d_mp", i), commit_mispredict_o, vt[i].mp);
      chk($sformatf("v%0d_pc", i), commit_pc_o, vt[i].cpc);
      chk($sformatf("v%0d_count", i), count_o, vt[i].cnt);
      chk($sformatf("v%0d_freed", i), commit_freed_reg_o, vt[i].cfr);
      chk($sformatf("v%0d_areg", i), commit_alloc_reg_o, {29'd0, vt[i].cfr[2:0]});
      chk($sformatf("v%0d_wv", i), commit_w_v_o, vt[i].cv);
      tick();
    end

    // full boundary and wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(16'h200 + 16'(2 * i), 7'(i), 0);
      #1;
      if (i == 15) begin
        chk("full_m1_ready", rob_ready_o, 1);
        chk("full_m1_count", count_o, 15);
      end
      tick();
    end
    alloc(16'hEEEE, 7'h7F, 0);
    #1;
    chk("full_ready", rob_ready_o, 0);
    chk("full_count", count_o, 16);
    chk("full_num", rob_num_o, 0);
    tick();
    chk("full_ignore_count", count_o, 16);
    idle();
    wb(0, 0, 0);
    tick();
    idle();
    alloc(16'hEEEE, 7'h7F, 0);
    #1;
    chk("full_commit_cv", commit_v_o, 1);
    chk("full_commit_ready", rob_ready_o, 0);
    chk("full_commit_freed", commit_freed_reg_o, 0);
    tick();
    chk("after_full_ready", rob_ready_o, 1);
    chk("after_full_count", count_o, 15);
    chk("after_full_num", rob_num_o, 0);
    alloc(16'h300, 7'h55, 0);
    tick();
    idle();
    #1;
    chk("wrap_count", count_o, 16);
    chk("wrap_num", rob_num_o, 1);
    chk("wrap_ready", rob_ready_o, 0);

    // mispredict flush
    do_reset();
    alloc(16'h100, 7'h10, 1);
    tick();
    for (int i = 1; i < 5; i++) begin
      alloc(16'h100 + 16'(2 * i), 7'(16 + i), 0);
      tick();
    end
    idle();
    wb(0, 1, 16'h40);
    tick();
    idle();
    wb(1, 0, 0);
    alloc(16'h500, 7'h66, 0);
    #1;
    chk("mp_cv", commit_v_o, 1);
    chk("mp_flag", commit_mispredict_o, 1);
    chk("mp_pc", commit_pc_o, 16'h40);
    chk("mp_ready", rob_ready_o, 0);
    chk("mp_count", count_o, 5);
    tick();
    idle();
    #1;
    chk("flush_count", count_o, 0);
    chk("flush_cv", commit_v_o, 0);
    chk("flush_num", rob_num_o, 1);
    chk("flush_ready", rob_ready_o, 1);
    alloc(16'h600, 7'h44, 0);
    tick();
    idle();
    tick();
    chk("post_flush_cv", commit_v_o, 0);
    chk("post_flush_count", count_o, 1);

    // steady state: alloc and commit each cycle
    do_reset();
    for (int k = 0; k < 44; k++) begin
      idle();
      alloc(16'h1000 + 16'(k), 7'(k), 0);
      if (k >= 1) wb(4'(k - 1), 0, 0);
      #1;
      if (k >= 2) begin
        chk($sformatf("ss%0d_count", k), count_o, 2);
        chk($sformatf("ss%0d_cv", k), commit_v_o, 1);
        chk($sformatf("ss%0d_freed", k), commit_freed_reg_o, 32'(7'(k - 2)));
      end
      tick();
    end

    // asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alloc(16'h700 + 16'(i), 7'(i + 3), 0);
      tick();
    end
    idle();
    wb(0, 0, 0);
    tick();
    idle();
    #1;
    chk("pre_rst_cv", commit_v_o, 1);
    chk("pre_rst_count", count_o, 6);
    #1;
    reset_i = 1;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_cv", commit_v_o, 0);
    chk("arst_num", rob_num_o, 0);
    chk("arst_ready", rob_ready_o, 1);
    chk("arst_freed", commit_freed_reg_o, 0);
    tick();
    reset_i = 0;
    alloc(16'h800, 7'h01, 0);
    #1;
    chk("rel_num", rob_num_o, 0);
    tick();
    idle();
    #1;
    chk("rel_num_next", rob_num_o, 1);
    chk("rel_count", count_o, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
